div_iter: RTL

Multi-cycle radix-2 restoring divider for the execute-stage ALU.
- It is the responder side of the ALU's divide handshake: the ALU holds start high and waits for ready, and can abort the operation with annul on an exception.
- It serves DIV and DIVU and returns {remainder, quotient} for direct write into HI/LO.
- It latches its operands at start, so later changes on the forwarding muxes do not affect the result.

---
 rtl/div_iter.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/div_iter.sv
// Multi-cycle radix-2 restoring divider for the execute-stage ALU.
// Serves DIV and DIVU and returns {remainder, quotient} for a direct HI/LO write.
// Operands are latched when start is accepted, so later changes on the
// forwarding muxes cannot disturb an operation in flight.
module div_iter #(
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            signed_div_i,
  input  logic [DW-1:0]   opdata1_i,
  input  logic [DW-1:0]   opdata2_i,
  input  logic            start_i,
  input  logic            annul_i,
  output logic [2*DW-1:0] result_o,
  output logic            ready_o
);

  localparam int CW = $clog2(DW) + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DZERO = 2'd1;
  localparam logic [1:0] S_BUSY  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]   quo_q, quo_d;     // dividend magnitude, shifted out as quotient bits shift in
  logic [DW-1:0]   rem_q, rem_d;     // partial remainder
  logic [DW-1:0]   dsr_q, dsr_d;     // divisor magnitude
  logic            qneg_q, qneg_d;   // quotient must be negated at the end
  logic            rneg_q, rneg_d;   // remainder must be negated (dividend was negative)
  logic [2*DW-1:0] result_q, result_d;
  logic            ready_q, ready_d;

  logic            op1_neg, op2_neg;
  logic [DW-1:0]   op1_mag, op2_mag;
  logic [DW:0]     trial, diff;
  logic [DW-1:0]   q_fix, r_fix;
  logic            last_iter;

  // Operand magnitudes; -(-2^(DW-1)) wraps to 2^(DW-1), which still fits unsigned.
  assign op1_neg = signed_div_i & opdata1_i[DW-1];
  assign op2_neg = signed_div_i & opdata2_i[DW-1];
  assign op1_mag = op1_neg ? -opdata1_i : opdata1_i;
  assign op2_mag = op2_neg ? -opdata2_i : opdata2_i;

  // One restoring step: shift the next dividend bit into the remainder and try a subtract.
  assign trial = {rem_q, quo_q[DW-1]};
  assign diff  = trial - {1'b0, dsr_q};

  // Sign fix-up of the final magnitudes; negating zero yields zero, so no negative zero.
  assign q_fix     = qneg_q ? -quo_q : quo_q;
  assign r_fix     = rneg_q ? -rem_q : rem_q;
  assign last_iter = (cnt_q == CW'(DW - 1));

  // Next-state and datapath decode for the four-state divide sequence.
  always_comb begin
    // NOTE: every variable gets a default first so no path through the case infers a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    dsr_d    = dsr_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    ready_d  = 1'b0;
    result_d = '0;

    case (state_q)
      S_IDLE: begin
        if (!annul_i && start_i) begin
          cnt_d = '0;
          rem_d = '0;
          if (opdata2_i == '0) begin
            state_d = S_DZERO;
            quo_d   = '0;
            dsr_d   = '0;
            qneg_d  = 1'b0;
            rneg_d  = 1'b0;
          end else begin
            state_d = S_BUSY;
            quo_d   = op1_mag;
            dsr_d   = op2_mag;
            qneg_d  = op1_neg ^ op2_neg;
            rneg_d  = op1_neg;
          end
        end
      end

      S_DZERO: begin
        state_d = annul_i ? S_IDLE : S_DONE;
      end

      S_BUSY: begin
        if (annul_i) begin
          state_d = S_IDLE;
        end else begin
          if (!diff[DW]) begin
            rem_d = diff[DW-1:0];
            quo_d = {quo_q[DW-2:0], 1'b1};
          end else begin
            rem_d = trial[DW-1:0];
            quo_d = {quo_q[DW-2:0], 1'b0};
          end
          cnt_d = cnt_q + CW'(1);
          if (last_iter) state_d = S_DONE;
        end
      end

      S_DONE: begin
        // The initiator holds start until it has seen ready; dropping it releases us.
        if (annul_i || !start_i) begin
          state_d = S_IDLE;
        end else begin
          ready_d  = 1'b1;
          result_d = {r_fix, q_fix};
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; an asynchronous reset discards any operation in flight.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      dsr_q    <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      result_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      dsr_q    <= dsr_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      result_q <= result_d;
      ready_q  <= ready_d;
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;

endmodule
